pipe_stall_ctrl: RTL and testbench

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_mdu_timer.sv | 64 ++++++
 rtl/pipe_stall_ctrl.sv | 101 ++++++++++
 tb/tb_pipe_stall_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stall controller: MDU FSM encoding,
// default multiply/divide latency and the stall counter saturation helper.
package pipe_pkg;

    localparam int MDU_LAT_DEFAULT = 32;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

    // Increment that sticks at the maximum instead of wrapping to zero
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == STALL_CNT_MAX) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/pipe_mdu_timer.sv
// Multiply/divide occupancy timer: IDLE -> BUSY for MDU_LAT-1 cycles -> DONE
// for one cycle, so the HI/LO write lands exactly MDU_LAT cycles after go.
module pipe_mdu_timer
    import pipe_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEFAULT
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       go,
    output logic [1:0] state
);

    localparam logic [5:0] LOAD_VAL = 6'(MDU_LAT - 2);

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic [5:0] cnt_r;
    logic [5:0] cnt_nxt_s;

    // Next-state and countdown logic
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (go) begin
                    state_nxt_s = ST_BUSY;
                    cnt_nxt_s   = LOAD_VAL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == 6'd0) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    cnt_nxt_s = cnt_r - 6'd1;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 6'd0;
            end
        endcase
    end

    // State and counter registers; clr abandons any operation in flight
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= ST_IDLE;
            cnt_r   <= 6'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign state = state_r;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard and stall controller: memory wait, load-use and HI/LO
// interlocks, branch flush, MDU sequencing and a saturating stall counter.
module pipe_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic [4:0]  ern,
    input  logic [4:0]  drs,
    input  logic [4:0]  drt,
    input  logic        duse_rs,
    input  logic        duse_rt,
    input  logic        duse_hilo,
    input  logic        mdu_start,
    input  logic        dbranch,
    input  logic        mwmem,
    input  logic        mm2reg,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        fd_en,
    output logic        de_en,
    output logic        em_en,
    output logic        de_bubble,
    output logic        fd_flush,
    output logic        mw_bubble,
    output logic        mdu_go,
    output logic        mdu_wr_hilo,
    output logic        mdu_busy,
    output logic [15:0] stall_cnt
);

    logic        mem_stall_s;
    logic        lu_stall_s;
    logic        hilo_stall_s;
    logic [1:0]  mdu_state_s;
    logic [15:0] stall_cnt_r;

    assign mem_stall_s  = (mwmem | mm2reg) & ~dmem_ready;
    assign lu_stall_s   = ewreg & em2reg & (ern != 5'd0) &
                          ((duse_rs & (ern == drs)) | (duse_rt & (ern == drt)));
    assign hilo_stall_s = (mdu_state_s != ST_IDLE) & (duse_hilo | mdu_start);

    assign mdu_go      = (mdu_state_s == ST_IDLE) & mdu_start & ~mem_stall_s & ~lu_stall_s;
    assign mdu_wr_hilo = (mdu_state_s == ST_DONE);
    assign mdu_busy    = (mdu_state_s != ST_IDLE);

    pipe_mdu_timer #(
        .MDU_LAT (MDU_LAT)
    ) u_mdu_timer (
        .clk   (clk),
        .clr   (clr),
        .go    (mdu_go),
        .state (mdu_state_s)
    );

    // Stage enables and bubbles; a memory wait freezes everything, an ID
    // interlock freezes only the front end, and a stalled branch is dropped
    always_comb begin
        pc_en     = 1'b1;
        fd_en     = 1'b1;
        de_en     = 1'b1;
        em_en     = 1'b1;
        de_bubble = 1'b0;
        fd_flush  = 1'b0;
        mw_bubble = 1'b0;
        if (mem_stall_s) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            de_en     = 1'b0;
            em_en     = 1'b0;
            mw_bubble = 1'b1;
        end else if (lu_stall_s | hilo_stall_s) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            de_bubble = 1'b1;
        end else if (dbranch) begin
            fd_flush  = 1'b1;
        end else begin
            de_bubble = 1'b0;
            fd_flush  = 1'b0;
        end
    end

    // Count every cycle in which the PC is held
    always_ff @(posedge clk) begin
        if (clr) begin
            stall_cnt_r <= 16'd0;
        end else if (!pc_en) begin
            stall_cnt_r <= sat_inc16(stall_cnt_r);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl with a 4-cycle MDU.
module tb_pipe_stall_ctrl;

    logic        clk;
    logic        clr;
    logic        ewreg, em2reg;
    logic [4:0]  ern, drs, drt;
    logic        duse_rs, duse_rt, duse_hilo;
    logic        mdu_start, dbranch;
    logic        mwmem, mm2reg, dmem_ready;
    logic        pc_en, fd_en, de_en, em_en;
    logic        de_bubble, fd_flush, mw_bubble;
    logic        mdu_go, mdu_wr_hilo, mdu_busy;
    logic [15:0] stall_cnt;

    int checks;
    int failures;

    pipe_stall_ctrl #(.MDU_LAT(4)) dut (
        .clk(clk), .clr(clr), .ewreg(ewreg), .em2reg(em2reg), .ern(ern),
        .drs(drs), .drt(drt), .duse_rs(duse_rs), .duse_rt(duse_rt),
        .duse_hilo(duse_hilo), .mdu_start(mdu_start), .dbranch(dbranch),
        .mwmem(mwmem), .mm2reg(mm2reg), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en),
        .de_bubble(de_bubble), .fd_flush(fd_flush), .mw_bubble(mw_bubble),
        .mdu_go(mdu_go), .mdu_wr_hilo(mdu_wr_hilo), .mdu_busy(mdu_busy),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ewreg = 1'b0; em2reg = 1'b0; ern = 5'd0; drs = 5'd0; drt = 5'd0;
        duse_rs = 1'b0; duse_rt = 1'b0; duse_hilo = 1'b0;
        mdu_start = 1'b0; dbranch = 1'b0;
        mwmem = 1'b0; mm2reg = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        do_reset();
        #1;
        checks++;
        if ({pc_en, fd_en, de_en, em_en} !== 4'b1111) begin
            $display("FAIL reset_enables got=%b exp=1111", {pc_en, fd_en, de_en, em_en}); failures++;
        end
        checks++;
        if ({de_bubble, fd_flush, mw_bubble, mdu_go, mdu_wr_hilo, mdu_busy} !== 6'b000000) begin
            $display("FAIL reset_flags got=%b exp=000000",
                     {de_bubble, fd_flush, mw_bubble, mdu_go, mdu_wr_hilo, mdu_busy}); failures++;
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); failures++;
        end
    endtask

    task automatic test_load_use();
        clear_inputs();
        do_reset();
        ewreg = 1'b1; em2reg = 1'b1; ern = 5'd5; drs = 5'd5; duse_rs = 1'b1;
        #1;
        checks++;
        if ({pc_en, fd_en, de_en, em_en, de_bubble, fd_flush, mw_bubble} !== 7'b0011100) begin
            $display("FAIL lu_rs_stall got=%b exp=0011100",
                     {pc_en, fd_en, de_en, em_en, de_bubble, fd_flush, mw_bubble}); failures++;
        end
        tick();
        ern = 5'd0; drs = 5'd0;
        #1;
        checks++;
        if ({pc_en, de_bubble} !== 2'b10) begin
            $display("FAIL lu_r0_nostall got=%b exp=10", {pc_en, de_bubble}); failures++;
        end
        checks++;
        if (stall_cnt !== 16'd1) begin
            $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); failures++;
        end
        duse_rs = 1'b0; ern = 5'd7; drt = 5'd7; duse_rt = 1'b1;
        #1;
        checks++;
        if ({pc_en, de_bubble} !== 2'b01) begin
            $display("FAIL lu_rt_stall got=%b exp=01", {pc_en, de_bubble}); failures++;
        end
        em2reg = 1'b0;
        #1;
        checks++;
        if ({pc_en, de_bubble} !== 2'b10) begin
            $display("FAIL lu_not_load got=%b exp=10", {pc_en, de_bubble}); failures++;
        end
        em2reg = 1'b1; drt = 5'd8;
        #1;
        checks++;
        if ({pc_en, de_bubble} !== 2'b10) begin
            $display("FAIL lu_rt_differs got=%b exp=10", {pc_en, de_bubble}); failures++;
        end
        clear_inputs();
    endtask

    task automatic test_mem_stall();
        clear_inputs();
        do_reset();
        mm2reg = 1'b1; dmem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({pc_en, fd_en, de_en, em_en, de_bubble, fd_flush, mw_bubble} !== 7'b0000001) begin
                $display("FAIL mem_stall_c%0d got=%b exp=0000001", c,
                         {pc_en, fd_en, de_en, em_en, de_bubble, fd_flush, mw_bubble}); failures++;
            end
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        checks++;
        if ({pc_en, fd_en, de_en, em_en, mw_bubble} !== 5'b11110) begin
            $display("FAIL mem_release got=%b exp=11110", {pc_en, fd_en, de_en, em_en, mw_bubble}); failures++;
        end
        checks++;
        if (stall_cnt !== 16'd3) begin
            $display("FAIL mem_stall_cnt got=%0d exp=3", stall_cnt); failures++;
        end
        // store wait outranks a simultaneous load-use hazard
        mm2reg = 1'b0; mwmem = 1'b1; dmem_ready = 1'b0;
        ewreg = 1'b1; em2reg = 1'b1; ern = 5'd3; drs = 5'd3; duse_rs = 1'b1;
        #1;
        checks++;
        if ({pc_en, de_en, em_en, de_bubble, mw_bubble} !== 5'b00001) begin
            $display("FAIL mem_over_lu got=%b exp=00001", {pc_en, de_en, em_en, de_bubble, mw_bubble}); failures++;
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        clear_inputs();
        do_reset();
        dbranch = 1'b1; ewreg = 1'b1; em2reg = 1'b1; ern = 5'd9; drs = 5'd9; duse_rs = 1'b1;
        #1;
        checks++;
        if ({pc_en, fd_flush, de_bubble} !== 3'b001) begin
            $display("FAIL branch_with_lu got=%b exp=001", {pc_en, fd_flush, de_bubble}); failures++;
        end
        ewreg = 1'b0;
        #1;
        checks++;
        if ({pc_en, fd_en, de_en, em_en, de_bubble, fd_flush, mw_bubble} !== 7'b1111010) begin
            $display("FAIL branch_alone got=%b exp=1111010",
                     {pc_en, fd_en, de_en, em_en, de_bubble, fd_flush, mw_bubble}); failures++;
        end
        clear_inputs();
    endtask

    task automatic test_mdu();
        logic [3:0] exp_go, exp_wr, exp_busy, exp_pc;
        clear_inputs();
        do_reset();
        // cycles 0..5: go at 0, busy 1-4, write at 4, HI/LO reader from cycle 2
        exp_go   = 4'b0001;
        exp_wr   = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            mdu_start = (c == 0);
            duse_hilo = (c >= 2);
            #1;
            checks++;
            if ({mdu_go, mdu_wr_hilo, mdu_busy, pc_en, de_bubble} !==
                {c == 0, c == 4, (c >= 1) && (c <= 4), !((c >= 2) && (c <= 4)), (c >= 2) && (c <= 4)}) begin
                $display("FAIL mdu_c%0d got go/wr/busy/pc/bub=%b exp=%b", c,
                         {mdu_go, mdu_wr_hilo, mdu_busy, pc_en, de_bubble},
                         {c == 0, c == 4, (c >= 1) && (c <= 4), !((c >= 2) && (c <= 4)), (c >= 2) && (c <= 4)});
                failures++;
            end
            tick();
        end
        exp_busy = exp_go ^ exp_wr;
        exp_pc   = exp_busy;
        checks++;
        if (stall_cnt !== 16'd3) begin
            $display("FAIL mdu_stall_cnt got=%0d exp=3 (%b%b)", stall_cnt, exp_busy, exp_pc); failures++;
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        do_reset();
        // go blocked by a memory wait, then accepted; memory wait during BUSY
        mdu_start = 1'b1; mm2reg = 1'b1; dmem_ready = 1'b0;
        #1;
        checks++;
        if (mdu_go !== 1'b0) begin
            $display("FAIL mdu_blocked got=%b exp=0", mdu_go); failures++;
        end
        tick();
        mm2reg = 1'b0; dmem_ready = 1'b1;
        #1;
        checks++;
        if ({mdu_go, mdu_busy} !== 2'b10) begin
            $display("FAIL mdu_accept got=%b exp=10", {mdu_go, mdu_busy}); failures++;
        end
        tick();
        mdu_start = 1'b0; mm2reg = 1'b1; dmem_ready = 1'b0;
        tick();
        tick();
        mm2reg = 1'b0; dmem_ready = 1'b1;
        tick();
        mdu_start = 1'b1;
        #1;
        checks++;
        if ({mdu_wr_hilo, mdu_go, pc_en} !== 3'b100) begin
            $display("FAIL start_in_done got=%b exp=100", {mdu_wr_hilo, mdu_go, pc_en}); failures++;
        end
        tick();
        #1;
        checks++;
        if ({mdu_busy, mdu_go, pc_en} !== 3'b011) begin
            $display("FAIL start_after_done got=%b exp=011", {mdu_busy, mdu_go, pc_en}); failures++;
        end
        tick();
        mdu_start = 1'b0;
        repeat (4) tick();
        clear_inputs();
    endtask

    task automatic test_clr_busy();
        int wr_seen;
        clear_inputs();
        do_reset();
        mdu_start = 1'b1;
        tick();
        mdu_start = 1'b0;
        tick();
        clr = 1'b1;
        #1;
        checks++;
        if (mdu_busy !== 1'b1) begin
            $display("FAIL clr_pre_busy got=%b exp=1", mdu_busy); failures++;
        end
        tick();
        clr = 1'b0;
        #1;
        checks++;
        if ({mdu_busy, mdu_wr_hilo} !== 2'b00) begin
            $display("FAIL clr_abort got=%b exp=00", {mdu_busy, mdu_wr_hilo}); failures++;
        end
        wr_seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (mdu_wr_hilo || mdu_busy) wr_seen++;
            tick();
        end
        checks++;
        if (wr_seen !== 0) begin
            $display("FAIL clr_no_write got=%0d exp=0", wr_seen); failures++;
        end
    endtask

    task automatic test_saturate();
        clear_inputs();
        do_reset();
        mm2reg = 1'b1; dmem_ready = 1'b0;
        repeat (65534) tick();
        checks++;
        if (stall_cnt !== 16'hFFFE) begin
            $display("FAIL sat_fffe got=%h exp=fffe", stall_cnt); failures++;
        end
        tick();
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            $display("FAIL sat_ffff got=%h exp=ffff", stall_cnt); failures++;
        end
        repeat (70000 - 65535) tick();
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            $display("FAIL sat_hold got=%h exp=ffff", stall_cnt); failures++;
        end
        clear_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clr      = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_mem_stall();
        test_branch();
        test_mdu();
        test_back_to_back();
        test_clr_busy();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
